// File: rtl/snake_step_scheduler.sv
// Snake step scheduler: arbitrates turn requests into a two-deep turn queue, paces movement steps, hands steps off valid/ready.
// Every output is registered. A step waits in step_valid until step_ready, and the tick counter stalls while a step is pending.
module snake_step_scheduler #(
   parameter int BASE_PERIOD = 6_250_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_up,
   input  logic       key_right,
   input  logic       key_down,
   input  logic       key_left,
   input  logic       ps2_valid,
   input  logic [7:0] ps2_code,
   input  logic [2:0] speed,
   input  logic       run,
   input  logic       step_ready,
   output logic       step_valid,
   output logic [1:0] step_dir,
   output logic [1:0] cur_dir,
   output logic       paused,
   output logic [1:0] q_count,
   output logic [7:0] drop_cnt
);
   localparam int            CW         = $clog2(BASE_PERIOD + 1);
   localparam logic [CW-1:0] BASE       = CW'(BASE_PERIOD);
   localparam logic [1:0]    DIR_UP     = 2'b00;
   localparam logic [1:0]    DIR_RIGHT  = 2'b01;
   localparam logic [1:0]    DIR_DOWN   = 2'b10;
   localparam logic [1:0]    DIR_LEFT   = 2'b11;
   localparam logic [7:0]    CODE_UP    = 8'h75;
   localparam logic [7:0]    CODE_RIGHT = 8'h74;
   localparam logic [7:0]    CODE_DOWN  = 8'h72;
   localparam logic [7:0]    CODE_LEFT  = 8'h6B;
   localparam logic [7:0]    CODE_PAUSE = 8'h29;

   logic [CW-1:0] tick_cnt;
   logic [CW-1:0] period;
   logic [CW-1:0] limit;
   logic [1:0]    q_slot0;
   logic [1:0]    q_slot1;
   logic [1:0]    ps2_dir;
   logic [1:0]    req_dir;
   logic [1:0]    ref_dir;
   logic          ps2_arrow;
   logic          ps2_pause;
   logic [2:0]    req_num;
   logic          req_any;
   logic          req_lost;
   logic          req_reject;
   logic          req_accept;
   logic          drop_inc;
   logic          hs;
   logic          pop;
   logic          tick_en;
   logic [1:0]    nxt_q0;
   logic [1:0]    nxt_q1;
   logic [1:0]    nxt_count;
   logic [1:0]    nxt_cur;

   always_comb begin
      ps2_arrow = 1'b0;
      ps2_dir   = DIR_UP;
      if (ps2_valid) begin
         case (ps2_code)
            CODE_UP:    begin ps2_arrow = 1'b1; ps2_dir = DIR_UP;    end
            CODE_RIGHT: begin ps2_arrow = 1'b1; ps2_dir = DIR_RIGHT; end
            CODE_DOWN:  begin ps2_arrow = 1'b1; ps2_dir = DIR_DOWN;  end
            CODE_LEFT:  begin ps2_arrow = 1'b1; ps2_dir = DIR_LEFT;  end
            default:    ;
         endcase
      end
   end

   assign ps2_pause = ps2_valid && (ps2_code == CODE_PAUSE);
   assign req_num   = {2'b00, key_up} + {2'b00, key_right} + {2'b00, key_down}
                    + {2'b00, key_left} + {2'b00, ps2_arrow};
   assign req_any   = (req_num != 3'd0);
   assign req_lost  = (req_num > 3'd1);

   always_comb begin
      if (key_up)         req_dir = DIR_UP;
      else if (key_right) req_dir = DIR_RIGHT;
      else if (key_down)  req_dir = DIR_DOWN;
      else if (key_left)  req_dir = DIR_LEFT;
      else                req_dir = ps2_dir;
   end

   // A new turn is judged against the last direction the snake will have taken before it.
   always_comb begin
      case (q_count)
         2'd1:    ref_dir = q_slot0;
         2'd2:    ref_dir = q_slot1;
         default: ref_dir = cur_dir;
      endcase
   end

   assign req_reject = (req_dir == ref_dir) || (req_dir == (ref_dir ^ 2'b10))
                     || (q_count == 2'd2) || paused || !run;
   assign req_accept = req_any && !req_reject;
   assign drop_inc   = req_any && (req_reject || req_lost);

   assign hs      = step_valid && step_ready;
   assign pop     = hs && (q_count != 2'd0);
   assign tick_en = !paused && !step_valid;
   assign period  = BASE >> speed;
   assign limit   = (period == '0) ? '0 : period - CW'(1);

   // Accept implies the pre-pop count was below 2, so push+pop only arises with one entry.
   always_comb begin
      nxt_q0    = q_slot0;
      nxt_q1    = q_slot1;
      nxt_count = q_count;
      nxt_cur   = hs ? step_dir : cur_dir;
      if (pop && req_accept) begin
         nxt_q0 = req_dir;
      end else if (pop) begin
         nxt_q0    = q_slot1;
         nxt_count = q_count - 2'd1;
      end else if (req_accept) begin
         if (q_count == 2'd0) nxt_q0 = req_dir;
         else                 nxt_q1 = req_dir;
         nxt_count = q_count + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt   <= '0;
         step_valid <= 1'b0;
         step_dir   <= DIR_RIGHT;
         cur_dir    <= DIR_RIGHT;
         paused     <= 1'b0;
         q_count    <= 2'd0;
         q_slot0    <= DIR_UP;
         q_slot1    <= DIR_UP;
         drop_cnt   <= 8'd0;
      end else begin
         if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
         if (!run) begin
            tick_cnt   <= '0;
            step_valid <= 1'b0;
            step_dir   <= DIR_RIGHT;
            cur_dir    <= DIR_RIGHT;
            paused     <= 1'b0;
            q_count    <= 2'd0;
         end else begin
            if (ps2_pause) paused <= !paused;
            q_slot0  <= nxt_q0;
            q_slot1  <= nxt_q1;
            q_count  <= nxt_count;
            cur_dir  <= nxt_cur;
            step_dir <= (nxt_count != 2'd0) ? nxt_q0 : nxt_cur;
            if (hs) begin
               step_valid <= 1'b0;
            end else if (tick_en) begin
               if (tick_cnt >= limit) begin
                  tick_cnt   <= '0;
                  step_valid <= 1'b1;
               end else begin
                  tick_cnt <= tick_cnt + CW'(1);
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_snake_step_scheduler.sv
// Bench for snake_step_scheduler: directed scenarios plus random traffic, all checked against a queue-based model.
module tb_snake_step_scheduler;
   localparam int BASE = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_up = 1'b0, key_right = 1'b0, key_down = 1'b0, key_left = 1'b0;
   logic       ps2_valid = 1'b0;
   logic [7:0] ps2_code = 8'h00;
   logic [2:0] speed = 3'd0;
   logic       run = 1'b0;
   logic       step_ready = 1'b0;
   logic       step_valid;
   logic [1:0] step_dir;
   logic [1:0] cur_dir;
   logic       paused;
   logic [1:0] q_count;
   logic [7:0] drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   int m_cnt    = 0;
   bit m_valid  = 0;
   int m_cur    = 1;
   bit m_paused = 0;
   int m_q[$];
   int m_drop   = 0;

   snake_step_scheduler #(.BASE_PERIOD(BASE)) dut (
      .clk(clk), .rst(rst),
      .key_up(key_up), .key_right(key_right), .key_down(key_down), .key_left(key_left),
      .ps2_valid(ps2_valid), .ps2_code(ps2_code), .speed(speed), .run(run),
      .step_ready(step_ready), .step_valid(step_valid), .step_dir(step_dir),
      .cur_dir(cur_dir), .paused(paused), .q_count(q_count), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: apply one clock edge of the specified behaviour to the abstract state.
   task automatic model_step();
      int reqs[$];
      int d, refd, lim;
      bit rej, acc, en, hs;
      if (rst) begin
         m_cnt = 0; m_valid = 0; m_cur = 1; m_paused = 0; m_q.delete(); m_drop = 0;
         return;
      end
      if (key_up)    reqs.push_back(0);
      if (key_right) reqs.push_back(1);
      if (key_down)  reqs.push_back(2);
      if (key_left)  reqs.push_back(3);
      if (ps2_valid) begin
         case (ps2_code)
            8'h75: reqs.push_back(0);
            8'h74: reqs.push_back(1);
            8'h72: reqs.push_back(2);
            8'h6B: reqs.push_back(3);
            default: ;
         endcase
      end
      acc = 0;
      d   = 0;
      if (reqs.size() > 0) begin
         d    = reqs[0];
         refd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_cur;
         rej  = (d == refd) || (d == (refd ^ 2)) || (m_q.size() == 2) || m_paused || !run;
         acc  = !rej;
         if ((rej || reqs.size() > 1) && m_drop < 255) m_drop++;
      end
      if (!run) begin
         m_cnt = 0; m_valid = 0; m_q.delete(); m_paused = 0; m_cur = 1;
         return;
      end
      en = !m_paused && !m_valid;
      hs = m_valid && step_ready;
      if (hs) begin
         if (m_q.size() > 0) m_cur = m_q.pop_front();
         m_valid = 0;
      end
      if (acc) m_q.push_back(d);
      if (en) begin
         lim = (BASE >> speed) - 1;
         if (m_cnt >= lim) begin
            m_cnt = 0; m_valid = 1;
         end else begin
            m_cnt++;
         end
      end
      if (ps2_valid && ps2_code == 8'h29) m_paused = !m_paused;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("step_valid", step_valid, m_valid);
      check("step_dir", step_dir, (m_q.size() > 0) ? m_q[0] : m_cur);
      check("cur_dir", cur_dir, m_cur);
      check("paused", paused, m_paused);
      check("q_count", q_count, m_q.size());
      check("drop_cnt", drop_cnt, m_drop);
   endtask

   task automatic clear_inputs();
      key_up = 0; key_right = 0; key_down = 0; key_left = 0; ps2_valid = 0; ps2_code = 8'h00;
   endtask

   task automatic press(input int dir);
      key_up = (dir == 0); key_right = (dir == 1); key_down = (dir == 2); key_left = (dir == 3);
      cycle();
      clear_inputs();
   endtask

   task automatic ps2(input logic [7:0] code);
      ps2_valid = 1; ps2_code = code;
      cycle();
      clear_inputs();
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1; run = 0; step_ready = 0;
      cycle();
      rst = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, step_valid, 0);
      check({tag, "_sdir"}, step_dir, 1);
      check({tag, "_cdir"}, cur_dir, 1);
      check({tag, "_paused"}, paused, 0);
      check({tag, "_qcnt"}, q_count, 0);
      check({tag, "_drop"}, drop_cnt, 0);
   endtask

   task automatic wait_valid(input int max);
      int n = 0;
      while (!step_valid && n < max) begin
         cycle();
         n++;
      end
      check("wait_valid", step_valid, 1);
   endtask

   task automatic handshake();
      wait_valid(64);
      step_ready = 1;
      cycle();
      step_ready = 0;
   endtask

   initial begin
      int hits[$];
      int n;

      do_reset();
      check_reset_values("reset");

      // Basic stepping at P=8 with ready tied high
      speed = 3'd1; step_ready = 1; run = 1;
      for (int i = 1; i <= 40; i++) begin
         cycle();
         if (step_valid) hits.push_back(i);
      end
      check("step_hits", hits.size(), 4);
      for (int k = 0; k < 4; k++)
         check("step_cycle", (k < hits.size()) ? hits[k] : -1, 8 + 9 * k);

      // Turn queue fill and full rejects
      do_reset();
      run = 1; speed = 3'd3;
      press(2); press(3); press(0); press(1);
      check("tq_count", q_count, 2);
      check("tq_drop", drop_cnt, 2);
      check("tq_head", step_dir, 2);
      handshake();
      check("tq_cur1", cur_dir, 2);
      handshake();
      check("tq_cur2", cur_dir, 3);
      check("tq_empty", q_count, 0);

      // Reversal and duplicate
      do_reset();
      run = 1; speed = 3'd0;
      press(3); press(1);
      check("rd_drop", drop_cnt, 2);
      check("rd_count", q_count, 0);
      ps2(8'h75);
      check("rd_dir", step_dir, 0);

      // Simultaneous request and handshake+push
      do_reset();
      run = 1; speed = 3'd3;
      key_down = 1; ps2_valid = 1; ps2_code = 8'h75;
      cycle();
      clear_inputs();
      check("sim_count", q_count, 1);
      check("sim_drop", drop_cnt, 1);
      check("sim_dir", step_dir, 2);
      handshake();
      press(3);
      check("sim_q1", q_count, 1);
      wait_valid(64);
      step_ready = 1; key_up = 1;
      cycle();
      step_ready = 0; clear_inputs();
      check("hspush_count", q_count, 1);
      check("hspush_dir", step_dir, 0);
      check("hspush_cur", cur_dir, 3);

      // Pause with counter at 5, resume latency
      do_reset();
      run = 1; speed = 3'd1;
      repeat (5) cycle();
      ps2(8'h29);
      check("pause_on", paused, 1);
      repeat (20) cycle();
      check("pause_hold", step_valid, 0);
      ps2(8'h29);
      n = 1;
      while (!step_valid && n < 12) begin
         cycle();
         n++;
      end
      check("resume_lat", n, 3);

      // Speed change with counter already past the new limit
      do_reset();
      run = 1; speed = 3'd0;
      repeat (10) cycle();
      check("spd_before", step_valid, 0);
      speed = 3'd1;
      cycle();
      check("spd_fire", step_valid, 1);

      // Run drop with a pending step and full queue
      do_reset();
      run = 1; speed = 3'd3;
      press(2); press(3); press(0);
      wait_valid(64);
      ps2(8'h29);
      check("rl_pre_valid", step_valid, 1);
      check("rl_pre_paused", paused, 1);
      check("rl_pre_count", q_count, 2);
      run = 0;
      cycle();
      check("rl_valid", step_valid, 0);
      check("rl_count", q_count, 0);
      check("rl_cur", cur_dir, 1);
      check("rl_paused", paused, 0);
      check("rl_drop", drop_cnt, 1);

      // Reset in the middle of a count
      run = 1; speed = 3'd0;
      repeat (3) cycle();
      press(1);
      check("mid_drop", drop_cnt, 2);
      rst = 1;
      cycle();
      rst = 0;
      check_reset_values("midrst");

      // Random traffic
      do_reset();
      run = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) run = !run;
         if ($urandom_range(0, 99) == 0) speed = 3'($urandom_range(0, 3));
         rst        = ($urandom_range(0, 599) == 0);
         step_ready = $urandom_range(0, 1) == 1;
         key_up     = run && ($urandom_range(0, 9) == 0);
         key_right  = run && ($urandom_range(0, 9) == 0);
         key_down   = run && ($urandom_range(0, 9) == 0);
         key_left   = run && ($urandom_range(0, 9) == 0);
         ps2_valid  = run && ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 6))
            0: ps2_code = 8'h75;
            1: ps2_code = 8'h74;
            2: ps2_code = 8'h72;
            3: ps2_code = 8'h6B;
            4: ps2_code = 8'h29;
            default: ps2_code = 8'($urandom_range(0, 255));
         endcase
         cycle();
      end
      clear_inputs();
      rst = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
